level_control_rr: RTL and testbench

- Parametrised per-level controller for the accelerator's search pipeline. It supersedes the fixed level-0 controller.
- It starts only when the global level selector matches LEVEL_ID. It then loads REG_CNT pattern registers from the host data bus and launches the level's search units.
- It round-robin arbitrates NUM_SU search-unit write requests onto a single result-queue write port, with backpressure from Qfull. It keeps a count of accepted writes.

---
 rtl/level_control_rr.sv | 143 ++++++++++++++
 tb/tb_level_control_rr.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/level_control_rr.sv
// Per-level search controller: gated start, pattern register load, search-unit
// launch, and round-robin arbitration of unit writes onto one result queue.
module level_control_rr #(
    parameter int unsigned LEVEL_ID = 0,
    parameter int unsigned LEVEL_W  = 3,
    parameter int unsigned NUM_SU   = 16,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned DATA_W   = 64,
    parameter int unsigned REG_CNT  = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stop,
    input  logic               startLC,
    input  logic [LEVEL_W-1:0] levels,
    input  logic [DATA_W-1:0]  dataToLC,
    output logic [REG_CNT-1:0] regEn,
    output logic [DATA_W-1:0]  dataToReg,
    output logic               startSU,
    output logic               stopSU,
    input  logic [NUM_SU-1:0]  writeReq,
    input  logic               Qfull,
    output logic               enableQ,
    output logic [SEL_W:0]     writeQen,
    output logic               incrPC,
    output logic [NUM_SU-1:0]  writeSucceeded,
    output logic               busy,
    output logic [CNT_W-1:0]   writeCount
);

    localparam int unsigned IDX_W = (REG_CNT > 1) ? $clog2(REG_CNT) : 1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        LAUNCH,
        RUN,
        HALT
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [IDX_W-1:0]   load_idx;
    logic [SEL_W-1:0]   ptr;
    logic               cand_found;
    logic [SEL_W-1:0]   cand_idx;
    logic               grant_valid;
    logic [SEL_W-1:0]   grant_idx;

    // Rotating priority scan: first requester at or after ptr, wrapping.
    always_comb begin
        cand_found = 1'b0;
        cand_idx   = '0;
        for (int unsigned off = 0; off < NUM_SU; off++) begin
            int unsigned pos;
            pos = 32'(ptr) + off;
            if (pos >= NUM_SU) begin
                pos = pos - NUM_SU;
            end
            if (!cand_found && writeReq[SEL_W'(pos)]) begin
                cand_found = 1'b1;
                cand_idx   = SEL_W'(pos);
            end
        end
    end

    always_comb begin
        state_next     = state;
        regEn          = '0;
        dataToReg      = '0;
        startSU        = 1'b0;
        stopSU         = 1'b0;
        enableQ        = 1'b0;
        writeQen       = '0;
        writeSucceeded = '0;
        grant_valid    = 1'b0;
        grant_idx      = '0;
        case (state)
            IDLE: begin
                if (startLC && (levels == LEVEL_W'(LEVEL_ID)) && !stop) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                regEn     = REG_CNT'(1) << load_idx;
                dataToReg = dataToLC;
                if (stop) begin
                    state_next = HALT;
                end else if (load_idx == IDX_W'(REG_CNT - 1)) begin
                    state_next = LAUNCH;
                end
            end
            LAUNCH: begin
                startSU    = 1'b1;
                state_next = stop ? HALT : RUN;
            end
            RUN: begin
                if (stop) begin
                    state_next = HALT;
                end else if (cand_found && !Qfull) begin
                    grant_valid    = 1'b1;
                    grant_idx      = cand_idx;
                    enableQ        = 1'b1;
                    writeQen       = {1'b1, cand_idx};
                    writeSucceeded = NUM_SU'(1) << cand_idx;
                end
            end
            HALT: begin
                stopSU     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    assign incrPC = enableQ;
    assign busy   = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            load_idx   <= '0;
            ptr        <= '0;
            writeCount <= '0;
        end else begin
            state <= state_next;
            if (state == IDLE && state_next == LOAD) begin
                load_idx   <= '0;
                writeCount <= '0;
            end else if (state == LOAD && state_next == LOAD) begin
                load_idx <= load_idx + IDX_W'(1);
            end
            if (grant_valid) begin
                ptr <= (grant_idx == SEL_W'(NUM_SU - 1)) ? '0 : grant_idx + SEL_W'(1);
                if (writeCount != '1) begin
                    writeCount <= writeCount + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_level_control_rr.sv
// Directed plus randomized bench for level_control_rr against a behavioural
// model of the controller's phases and round-robin queue arbitration.
module tb_level_control_rr;

    localparam int NSU = 16;
    localparam int CW  = 5;

    logic        clk = 1'b0;
    logic        rst, stop, startLC, Qfull;
    logic [2:0]  levels;
    logic [63:0] dataToLC;
    logic [15:0] writeReq;
    logic [3:0]  regEn;
    logic [63:0] dataToReg;
    logic        startSU, stopSU, enableQ, incrPC, busy;
    logic [4:0]  writeQen;
    logic [15:0] writeSucceeded;
    logic [CW-1:0] writeCount;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: phases held as independent flags, not as an encoded state.
    int load_pos   = -1;
    bit launch_due = 0;
    bit running    = 0;
    bit halt_due   = 0;
    int m_ptr      = 0;
    int m_cnt      = 0;

    level_control_rr #(
        .LEVEL_ID(0), .LEVEL_W(3), .NUM_SU(16), .SEL_W(4),
        .DATA_W(64), .REG_CNT(4), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .stop(stop), .startLC(startLC), .levels(levels),
        .dataToLC(dataToLC), .regEn(regEn), .dataToReg(dataToReg),
        .startSU(startSU), .stopSU(stopSU), .writeReq(writeReq), .Qfull(Qfull),
        .enableQ(enableQ), .writeQen(writeQen), .incrPC(incrPC),
        .writeSucceeded(writeSucceeded), .busy(busy), .writeCount(writeCount)
    );

    always #5 clk = ~clk;

    function automatic int find_cand(input logic [15:0] req, input int p);
        for (int k = 0; k < NSU; k++) begin
            int i;
            i = (p + k) % NSU;
            if (req[i]) return i;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cycle();
        int  g;
        bit  idle;
        @(negedge clk);
        g = (running && !stop && !Qfull) ? find_cand(writeReq, m_ptr) : -1;
        idle = !(load_pos >= 0 || launch_due || running || halt_due);
        chk("busy", 64'(busy), 64'(!idle));
        chk("regEn", 64'(regEn), load_pos >= 0 ? (64'd1 << load_pos) : 64'd0);
        chk("dataToReg", dataToReg, load_pos >= 0 ? dataToLC : 64'd0);
        chk("startSU", 64'(startSU), 64'(launch_due));
        chk("stopSU", 64'(stopSU), 64'(halt_due));
        chk("enableQ", 64'(enableQ), 64'(g >= 0));
        chk("incrPC", 64'(incrPC), 64'(g >= 0));
        chk("writeQen", 64'(writeQen), g >= 0 ? 64'(16 + g) : 64'd0);
        chk("writeSucceeded", 64'(writeSucceeded), g >= 0 ? (64'd1 << g) : 64'd0);
        chk("writeCount", 64'(writeCount), 64'(m_cnt));
        if (rst) begin
            load_pos = -1; launch_due = 0; running = 0; halt_due = 0;
            m_ptr = 0; m_cnt = 0;
        end else if (halt_due) begin
            halt_due = 0;
        end else if (idle) begin
            if (startLC && levels == 3'd0 && !stop) begin
                load_pos = 0;
                m_cnt    = 0;
            end
        end else if (stop) begin
            load_pos = -1; launch_due = 0; running = 0; halt_due = 1;
        end else if (load_pos >= 0) begin
            if (load_pos == 3) begin
                load_pos   = -1;
                launch_due = 1;
            end else begin
                load_pos++;
            end
        end else if (launch_due) begin
            launch_due = 0;
            running    = 1;
        end else if (g >= 0) begin
            m_ptr = (g + 1) % NSU;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic start_and_load(input logic [63:0] d);
        levels = 3'd0; startLC = 1'b1;
        cycle();
        startLC = 1'b0; dataToLC = d;
        repeat (5) cycle();
    endtask

    initial begin
        rst = 1'b1; stop = 1'b0; startLC = 1'b0; Qfull = 1'b0;
        levels = 3'd0; dataToLC = '0; writeReq = '0;
        repeat (2) @(posedge clk);
        #1;
        cycle();
        rst = 1'b0;
        cycle();

        // Level gating, then load and launch
        levels = 3'd1; startLC = 1'b1;
        repeat (2) cycle();
        start_and_load(64'hFFF0F0F0F0F0F0FF);

        // Single request
        writeReq = 16'h0001;
        cycle();
        // Round robin between two persistent requesters
        writeReq = 16'h8001;
        repeat (4) cycle();
        // Backpressure then release
        writeReq = 16'h0020; Qfull = 1'b1;
        repeat (4) cycle();
        Qfull = 1'b0;
        cycle();

        // Stop masks the grant in the cycle it is sampled
        writeReq = 16'h0500; stop = 1'b1;
        cycle();
        stop = 1'b0;
        repeat (2) cycle();
        start_and_load(64'h0123456789ABCDEF);
        writeReq = 16'hFFFF;
        repeat (3) cycle();

        // Reset while the second register is being written
        writeReq = '0; stop = 1'b1;
        cycle();
        stop = 1'b0;
        cycle();
        levels = 3'd0; startLC = 1'b1;
        cycle();
        startLC = 1'b0;
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        repeat (2) cycle();

        // Randomized traffic; long runs let writeCount reach saturation
        for (int n = 0; n < 800; n++) begin
            writeReq = 16'($urandom) & 16'($urandom);
            Qfull    = ($urandom % 4) == 0;
            stop     = ($urandom % 150) == 0;
            startLC  = $urandom % 2;
            levels   = 3'($urandom % 3);
            dataToLC = {$urandom, $urandom};
            rst      = ($urandom % 400) == 0;
            cycle();
        end
        rst = 1'b0; stop = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
